// File: rtl/pool2x2_scheduler.sv
// 2x2 stride-2 pooling sequencer over a raster pixel stream (max pool by default).
// Define POOL_AVG_EN to switch to floor-average pooling with a one-bit-wider line buffer.
module pool2x2_scheduler #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done,
  output logic              sync_err
);
  localparam int CW       = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW       = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int LW       = (CW > 1) ? CW - 1 : 1;
  localparam int LB_DEPTH = 1 << LW;
`ifdef POOL_AVG_EN
  localparam int LB_W = DATA_W + 1;
`else
  localparam int LB_W = DATA_W;
`endif
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_w
    $error("pool2x2_scheduler: IMG_W must be even and >= 2");
  end
  if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_h
    $error("pool2x2_scheduler: IMG_H must be even and >= 2");
  end

  typedef enum logic {ROW_EVEN = 1'b0, ROW_ODD = 1'b1} state_t;

  logic [CW-1:0]            col, col_nxt, eff_col;
  logic [RW-1:0]            row, row_nxt, eff_row;
  logic [LW-1:0]            lb_idx;
  logic signed [DATA_W-1:0] pair_reg, px, res;
  logic signed [LB_W-1:0]   linebuf [LB_DEPTH];
  logic signed [LB_W-1:0]   lb_rd, lb_wdata;
  logic                     take, sof_err, last_px, lb_we, res_ld;
  state_t                   state;

  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready && !clear;
  // A misplaced SOF resynchronises: the pixel is handled as (0,0) of a new frame.
  assign sof_err  = take && in_sof && (row != '0 || col != '0);
  assign eff_col  = sof_err ? '0 : col;
  assign eff_row  = sof_err ? '0 : row;
  assign last_px  = (eff_row == ROW_MAX) && (eff_col == COL_MAX);
  assign state    = state_t'(eff_row[0]);
  assign px       = $signed(in_data);

  if (CW > 1) begin : g_idx
    assign lb_idx = eff_col[CW-1:1];
  end else begin : g_idx0
    assign lb_idx = '0;
  end
  assign lb_rd = linebuf[lb_idx];

  // Position counters; the row parity is the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (take) begin
      if (eff_col == COL_MAX) begin
        col_nxt = '0;
        row_nxt = (eff_row == ROW_MAX) ? '0 : eff_row + 1'b1;
      end else begin
        col_nxt = eff_col + 1'b1;
        row_nxt = eff_row;
      end
    end
  end

  always_comb begin
    lb_we  = take && eff_col[0] && (state == ROW_EVEN);
    res_ld = take && eff_col[0] && (state == ROW_ODD);
`ifdef POOL_AVG_EN
    begin
      logic signed [DATA_W+1:0] sum3;
      lb_wdata = $signed({pair_reg[DATA_W-1], pair_reg}) + $signed({px[DATA_W-1], px});
      sum3 = $signed({lb_rd[LB_W-1], lb_rd})
           + $signed({{2{pair_reg[DATA_W-1]}}, pair_reg})
           + $signed({{2{px[DATA_W-1]}}, px});
      sum3 = sum3 >>> 2;
      res  = sum3[DATA_W-1:0];
    end
`else
    lb_wdata = (pair_reg > px) ? pair_reg : px;
    res      = (lb_rd > lb_wdata) ? lb_rd : lb_wdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (lb_we) linebuf[lb_idx] <= lb_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_reg   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else if (clear) begin
      pair_reg   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      if (take && !eff_col[0]) pair_reg <= px;
      if (res_ld) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_last  <= last_px;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      frame_done <= take && last_px;
      sync_err   <= sof_err;
    end
  end
endmodule

// File: tb/tb_pool2x2_scheduler.sv
// Directed vector bench for pool2x2_scheduler on a 4x4 image.
module tb_pool2x2_scheduler;
  logic        clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic        in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_ready, out_valid, out_last, frame_done, sync_err;
  logic [15:0] out_data;
  int          n_vec = 0, n_bad = 0;

  pool2x2_scheduler #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .frame_done(frame_done), .sync_err(sync_err));

  always #5 clk = ~clk;

  typedef struct {
    bit v; logic [15:0] d; bit sof, ordy, clr;
    bit e_ov; logic [15:0] e_od; bit e_ol, e_fd, e_se, e_ir;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vector %0d): got %0d expected %0d", name, n_vec, act, exp);
    end
  endtask

  // Pooled value of the quad completed at raster index i of a ramp starting at base.
  function automatic logic [15:0] q(input int base, input int i);
`ifdef POOL_AVG_EN
    return 16'(base + i - 3);
`else
    return 16'(base + i);
`endif
  endfunction

  task automatic add(input bit v, input int d, input bit sof, input bit ordy, input bit clr,
                     input bit ov, input int od, input bit ol, input bit fd, input bit se, input bit ir);
    vec_t t;
    t.v = v; t.d = 16'(d); t.sof = sof; t.ordy = ordy; t.clr = clr;
    t.e_ov = ov; t.e_od = 16'(od); t.e_ol = ol; t.e_fd = fd; t.e_se = se; t.e_ir = ir;
    tbl.push_back(t);
  endtask

  // Ramp pixels base+from .. base+to with out_ready=1; outputs at raster 5,7,13,15.
  task automatic add_seg(input int base, input int from, input int to, input bit sof, input bit se);
    for (int i = from; i <= to; i++) begin
      bit o;
      o = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      add(1, base + i, sof && i == from, 1, 0, o, int'(q(base, i)), i == 15, i == 15,
          se && i == from, 1);
    end
  endtask

  task automatic apply(input vec_t t);
    @(negedge clk);
    in_valid = t.v; in_data = t.d; in_sof = t.sof; out_ready = t.ordy; clear = t.clr;
    @(posedge clk); #1;
    n_vec++;
    chk("out_valid", 16'(out_valid), 16'(t.e_ov));
    if (t.e_ov) begin
      chk("out_data", out_data, t.e_od);
      chk("out_last", 16'(out_last), 16'(t.e_ol));
    end
    chk("frame_done", 16'(frame_done), 16'(t.e_fd));
    chk("sync_err", 16'(sync_err), 16'(t.e_se));
    chk("in_ready", 16'(in_ready), 16'(t.e_ir));
  endtask

  initial begin
    // Plain ramp frame, then an idle cycle.
    add_seg(0, 0, 15, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    // Signed compare: all -8 except raster 5 (row 1, col 1) = -3.
    for (int i = 0; i < 16; i++) begin
      int od;
`ifdef POOL_AVG_EN
      od = (i == 5) ? -7 : -8;
`else
      od = (i == 5) ? -3 : -8;
`endif
      add(1, (i == 5) ? -3 : -8, i == 0, 1, 0, i == 5 || i == 7 || i == 13 || i == 15,
          od, i == 15, i == 15, 0, 1);
    end
    // Backpressure: hold pixel 26 for five stalled cycles after the first result.
    add_seg(20, 0, 5, 1, 0);
    for (int k = 0; k < 5; k++) add(1, 26, 0, 0, 0, 1, int'(q(20, 5)), 0, 0, 0, 0);
    add_seg(20, 6, 15, 0, 0);
    // Misplaced SOF on the 7th pixel restarts the frame.
    add_seg(100, 0, 5, 1, 0);
    add_seg(200, 0, 15, 1, 1);
    // Clear drops a pending result, then a clean frame without SOF.
    add_seg(40, 0, 5, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add_seg(60, 0, 15, 0, 0);
    // Clear together with pixel 3: that pixel is discarded.
    add_seg(80, 0, 2, 1, 0);
    add(1, 83, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    add_seg(0, 0, 15, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    chk("rst out_valid", 16'(out_valid), 16'd0);
    chk("rst out_data", out_data, 16'd0);
    chk("rst out_last", 16'(out_last), 16'd0);
    chk("rst frame_done", 16'(frame_done), 16'd0);
    chk("rst sync_err", 16'(sync_err), 16'd0);
    chk("rst in_ready", 16'(in_ready), 16'd1);
    @(negedge clk) rst = 1'b0;

    foreach (tbl[k]) apply(tbl[k]);

    // Asynchronous reset mid-frame with a result pending and downstream stalled.
    tbl.delete();
    add_seg(0, 0, 7, 1, 0);
    foreach (tbl[k]) apply(tbl[k]);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    #1;
    n_vec++;
    chk("async rst out_valid", 16'(out_valid), 16'd0);
    chk("async rst out_data", out_data, 16'd0);
    chk("async rst in_ready", 16'(in_ready), 16'd1);
    @(negedge clk) rst = 1'b0;
    tbl.delete();
    add_seg(0, 0, 15, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    foreach (tbl[k]) apply(tbl[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
